bit_interval_meter: RTL
=======================

Name: bit_interval_meter

Overview:
- Consumes the 1-bit output of the single-pole bit low-pass filter and measures how long the filtered bit stays at each level.
- Applies a persistence check of MIN_HOLD samples so that residual chatter is not reported as a transition.
- Reports each completed interval (its level, its length in enabled samples, and a saturation flag) through a valid/ready output slot.
- Runs on the same `en` strobe as the filter, so lengths are in filter-rate samples.

Parameters:
- CNT_WIDTH, 16, width of the interval counter and of outCount.
- MIN_HOLD, 4, consecutive differing samples required to accept a level change. Legal range 1 to 255; a value of 1 accepts a change immediately.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  sample strobe; dataIn is evaluated only in cycles where en=1
- dataIn  in  1  filtered bit from the upstream low-pass filter
- outReady  in  1  consumer accepts the current result
- outValid  out  1  result slot full
- outLevel  out  1  level of the interval that just ended
- outCount  out  CNT_WIDTH  interval length in en samples, saturating
- outSat  out  1  outCount saturated at 2^CNT_WIDTH-1
- dropped  out  1  sticky flag: a result was lost because the slot was full

Behaviour:
- Reset, when rst=1 at a clock edge:
  - state=SYNC; curLevel=0; holdCnt=0; cnt=0.
  - outValid=0, outLevel=0, outCount=0, outSat=0, dropped=0.
  - rst has priority over all other inputs, including an in-progress handshake.
- When en=0, the internal state (state, curLevel, holdCnt, cnt) is unchanged. Only the output handshake logic runs.
- Persistence check, evaluated on each en sample:
  - If dataIn == curLevel, then holdCnt <= 0.
  - Otherwise holdCnt <= holdCnt+1.
  - A change is accepted on the sample where holdCnt+1 == MIN_HOLD. On that sample: curLevel <= dataIn and holdCnt <= 0.
- Interval counter, evaluated on each en sample:
  - On a non-accepting sample: cnt <= min(cnt+1, 2^CNT_WIDTH-1).
  - On an accepting sample: the measured length is L = min(cnt+1, 2^CNT_WIDTH-1), and cnt <= 0.
  - The measured length therefore equals the number of en samples between the two accepted changes. Because both changes are delayed by the same MIN_HOLD, the delay cancels.
  - Samples spent inside a rejected glitch count toward the current interval.
- State machine:
  - SYNC: the first interval after reset is partial. On the first accepted change, go to MEASURE and report nothing; cnt is cleared.
  - MEASURE: each accepted change produces a result with outLevel = the old curLevel, outCount = L, and outSat = 1 when cnt+1 reached 2^CNT_WIDTH-1 (the value is saturated). The state stays MEASURE until reset.
- Output slot (single entry, no skid buffer):
  - A result loads if outValid=0, or if outValid=1 and outReady=1 in the same cycle.
  - On load, outValid=1 from the next clock. Latency is 1 clk after the accepting en cycle.
  - If the slot is full and outReady=0, the new result is discarded, the slot keeps its old contents, and dropped <= 1. dropped clears only on rst.
  - If outValid=1, outReady=1 and there is no new result, then outValid <= 0.
  - outLevel, outCount and outSat are stable while outValid=1 and outReady=0.
  - outReady while outValid=0 has no effect.
- Arithmetic:
  - All counters are unsigned.
  - holdCnt is sized to hold MIN_HOLD.
  - cnt never wraps.

Test Plan (CNT_WIDTH=8, MIN_HOLD=4, en=1 and outReady=1 unless stated):
- Reset, then dataIn=0 for 10 clk, then 1 for 20 clk, then 0 for 30 clk, then 1 -> no output for the 0→1 change (SYNC). Then two results: level=1 count=20 sat=0, followed by level=0 count=30 sat=0. outValid pulses 1 clk after the 4th sample of each new level.
- In MEASURE at level 0, inject 3-sample high glitches (once, then repeatedly) within a 50-sample low interval, then go high -> no result from any glitch; the low interval reports count=50.
- Hold a level for 300 samples, then toggle -> count=255, sat=1. The next interval of 10 samples reports count=10, sat=0.
- outReady=0, produce two accepted changes -> first result held stable, second discarded, dropped=1. Then raise outReady for 1 clk together with a third accepted change -> the third result is loaded in that same cycle and outValid stays 1.
- en=1 every 4th clk, with a 12-sample high interval -> count=12 (not 48); nothing changes on en=0 cycles.
- Assert rst for 1 clk mid-interval while outValid=1 -> all outputs become 0 and state returns to SYNC; the next accepted change produces no result.

Source files
------------

// File: rtl/bit_interval_meter.sv
// Measures how long a filtered bit stays at each level, with persistence
// filtering, and reports each completed interval through a one-entry slot.
module bit_interval_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int MIN_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dataIn,
  input  logic                 outReady,
  output logic                 outValid,
  output logic                 outLevel,
  output logic [CNT_WIDTH-1:0] outCount,
  output logic                 outSat,
  output logic                 dropped
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [HW-1:0] HOLD = HW'(MIN_HOLD);

  typedef enum logic {
    SYNC,
    MEASURE
  } state_t;

  state_t state;
  state_t stateNext;

  logic                 curLevel;
  logic [HW-1:0]        holdCnt;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 diff;
  logic [HW-1:0]        holdInc;
  logic                 accept;
  logic                 sat;
  logic [CNT_WIDTH-1:0] len;
  logic                 newRes;
  logic                 load;
  logic                 lose;
  logic                 free;

  assign diff    = dataIn != curLevel;
  assign holdInc = holdCnt + 1'b1;
  assign accept  = en && diff && (holdInc == HOLD);
  // cnt+1 reaching the ceiling is treated as saturated
  assign sat     = cnt >= CMAX - 1'b1;
  assign len     = sat ? CMAX : cnt + 1'b1;

  always_comb begin
    stateNext = state;
    newRes    = 1'b0;
    if (accept) begin
      stateNext = MEASURE;
      newRes    = state == MEASURE;
    end
  end

  assign load = newRes && (!outValid || outReady);
  assign lose = newRes && outValid && !outReady;
  assign free = !newRes && outValid && outReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      curLevel <= 1'b0;
      holdCnt  <= '0;
      cnt      <= '0;
    end else begin
      state <= stateNext;
      if (en) begin
        if (accept) begin
          curLevel <= dataIn;
          holdCnt  <= '0;
          cnt      <= '0;
        end else begin
          holdCnt <= diff ? holdInc : '0;
          cnt     <= len;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outLevel <= 1'b0;
      outCount <= '0;
      outSat   <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      unique case (1'b1)
        load: begin
          outValid <= 1'b1;
          outLevel <= curLevel;
          outCount <= len;
          outSat   <= sat;
        end
        lose: dropped  <= 1'b1;
        free: outValid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
